keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Scans the 4x4 calculator matrix keypad, debounces it and turns each accepted keypress into
//  one (tipo, number) key event for the calculator FSM directly downstream.
//  tipo=0 digit 0-9; tipo=1 sign key: + 1010, - 1011, = 1100, reset 1111, spare 1101/1110.
//  One event per physical press; no rollover, no auto-repeat.
// PARAMETERS
//  SCAN_DIV  1000  clk cycles per scan tick (column dwell); legal range >= 4 (row sync settle)
//  DEBOUNCE  4     consecutive identical scan ticks needed to accept a press or a release; >= 1
// PORTS
//  clk         in   1  system clock
//  reset       in   1  asynchronous, active-high reset
//  row_n       in   4  keypad rows, active-low, pulled up, asynchronous to clk
//  col_n       out  4  keypad column drive, active-low, exactly one column low at a time
//  tipo        out  1  key type of last accepted key: 0 digit, 1 sign
//  number      out  4  code of last accepted key
//  key_strobe  out  1  one-cycle pulse, tipo/number valid and new in that cycle
//  key_down    out  1  high from strobe until release is debounced
// BEHAVIOUR
//  Reset (async): col_n=4'b1110, tipo=0, number=0, key_strobe=0, key_down=0, tick and debounce
//   counters=0, state SCAN. Reset mid-operation discards any partial press; no strobe is emitted.
//  row_n passes a 2-flop synchronizer; all decisions use synced rows, sampled only on scan tick.
//  Tick: counter 0..SCAN_DIV-1, tick at terminal count, counter wraps to 0.
//  Key map (row,col): r0: 1 2 3 + | r1: 4 5 6 - | r2: 7 8 9 = | r3: reset 0 1110 1101.
//  States:
//   SCAN     on tick: exactly one synced row low -> latch (row,col), clear count, DEBOUNCE,
//            column held. No row low or >=2 rows low (ghost) -> rotate 1110>1101>1011>0111>1110.
//   DEBOUNCE column held; on tick: same single row low -> count+1; count==DEBOUNCE -> PRESSED.
//            Any other pattern -> count=0, rotate column, SCAN.
//   PRESSED  one cycle: tipo/number <= decoded code, key_strobe=1, key_down=1 -> RELEASE.
//   RELEASE  column held; on tick: all rows high -> rel_count+1, else rel_count=0.
//            rel_count==DEBOUNCE -> key_down=0, rotate column, SCAN. Other keys ignored here.
//  tipo/number hold last accepted value until next strobe; key_strobe never high 2 cycles.
//  Latency: first stable-low tick to strobe = DEBOUNCE ticks + 1 cycle (+2 sync cycles from pin).
//  Same key pressed again only after full debounced release -> new strobe.
// STRUCTURE
//  Shared include calc_defs.vh: KEY_PLUS 4'b1010, KEY_MINUS 4'b1011, KEY_EQUAL 4'b1100,
//   KEY_RESET 4'b1111, TIPO_NUM 0, TIPO_SIGN 1; also used by the calculator FSM.
//  State encoding localparams SCAN/DEBOUNCE/PRESSED/RELEASE local to this module.
//  Sub-module sync_2ff (4-bit, async reset to 1s) for row_n; decode is a local function.
// TESTING  (SCAN_DIV=4, DEBOUNCE=3; keypad model pulls row low when its column is driven low)
//  1 reset held 20 cycles -> col_n=1110, tipo=0, number=0, key_strobe=0, key_down=0.
//  2 hold key r1c1 200 cycles then release -> exactly one strobe, tipo=0, number=0101;
//    key_down high until 3 release ticks; scanning resumes at col_n=0111 after 1011.
//  3 press r2c3 '=' -> strobe with tipo=1, number=1100; press r3c0 -> tipo=1, number=1111.
//  4 r0c0 bounces low/high for 2 ticks then stable -> one strobe number=0001;
//    2-tick glitch alone -> no strobe.
//  5 r0c2 and r1c2 low together -> no strobe, column keeps rotating.
//  6 reset pulse during DEBOUNCE of key 9 -> outputs cleared, no strobe; key still held after
//    reset -> one strobe number=1001 after a fresh DEBOUNCE.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
// Shared key codes, scanner state type and the keypad position-to-code decoder.
// The calculator FSM downstream relies on the same key codes.
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } scan_state_t;

  localparam logic [3:0] KEY_PLUS  = 4'b1010;
  localparam logic [3:0] KEY_MINUS = 4'b1011;
  localparam logic [3:0] KEY_EQUAL = 4'b1100;
  localparam logic [3:0] KEY_RESET = 4'b1111;
  localparam logic       TIPO_NUM  = 1'b0;
  localparam logic       TIPO_SIGN = 1'b1;

  // Layout: r0 = 1 2 3 +, r1 = 4 5 6 -, r2 = 7 8 9 =, r3 = reset 0 spare spare
  function automatic logic [3:0] decode_key(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'd1;
      4'h1: code = 4'd2;
      4'h2: code = 4'd3;
      4'h3: code = KEY_PLUS;
      4'h4: code = 4'd4;
      4'h5: code = 4'd5;
      4'h6: code = 4'd6;
      4'h7: code = KEY_MINUS;
      4'h8: code = 4'd7;
      4'h9: code = 4'd8;
      4'hA: code = 4'd9;
      4'hB: code = KEY_EQUAL;
      4'hC: code = KEY_RESET;
      4'hD: code = 4'd0;
      4'hE: code = 4'b1110;
      default: code = 4'b1101;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pins plus the key-event outputs consumed by the calculator FSM.
interface keypad_scanner_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic       tipo;
  logic [3:0] number;
  logic       key_strobe;
  logic       key_down;

  modport master (input row_n, output col_n, tipo, number, key_strobe, key_down);
  modport slave  (output row_n, input col_n, tipo, number, key_strobe, key_down);
endinterface

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for the asynchronous keypad rows; resets to the idle (all high) level.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column rotation, press/release debounce and one key event per press.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic              clk,
  input  logic              reset,
  keypad_scanner_if.master  kp
);

  localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);

  scan_state_t   state;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [CW-1:0] count;
  logic [3:0]    row_s;
  logic          single_low;
  logic [1:0]    row_idx;
  logic [1:0]    col_idx;
  logic [1:0]    key_row;
  logic [1:0]    key_col;
  logic [3:0]    key_code;

  sync_2ff #(.WIDTH(4)) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (kp.row_n),
    .q     (row_s)
  );

  assign tick = (tick_cnt == TW'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + 1'b1;
  end

  // Two or more rows low on one column is a ghosting pattern and is treated as no key
  always_comb begin
    single_low = 1'b0;
    row_idx    = 2'd0;
    case (row_s)
      4'b1110: begin single_low = 1'b1; row_idx = 2'd0; end
      4'b1101: begin single_low = 1'b1; row_idx = 2'd1; end
      4'b1011: begin single_low = 1'b1; row_idx = 2'd2; end
      4'b0111: begin single_low = 1'b1; row_idx = 2'd3; end
      default: begin single_low = 1'b0; row_idx = 2'd0; end
    endcase
    case (kp.col_n)
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
    key_code = decode_key(key_row, key_col);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_SCAN;
      kp.col_n      <= 4'b1110;
      kp.tipo       <= TIPO_NUM;
      kp.number     <= 4'd0;
      kp.key_strobe <= 1'b0;
      kp.key_down   <= 1'b0;
      count         <= '0;
      key_row       <= 2'd0;
      key_col       <= 2'd0;
    end else begin
      kp.key_strobe <= 1'b0;
      case (state)
        ST_SCAN: begin
          if (tick) begin
            if (single_low) begin
              key_row <= row_idx;
              key_col <= col_idx;
              count   <= '0;
              state   <= ST_DEBOUNCE;
            end else begin
              kp.col_n <= {kp.col_n[2:0], kp.col_n[3]};
            end
          end
        end
        ST_DEBOUNCE: begin
          if (tick) begin
            if (single_low && (row_idx == key_row)) begin
              if (count == CW'(DEBOUNCE - 1)) begin
                count <= '0;
                state <= ST_PRESSED;
              end else begin
                count <= count + 1'b1;
              end
            end else begin
              count    <= '0;
              kp.col_n <= {kp.col_n[2:0], kp.col_n[3]};
              state    <= ST_SCAN;
            end
          end
        end
        ST_PRESSED: begin
          kp.number     <= key_code;
          kp.tipo       <= (key_code >= 4'd10) ? TIPO_SIGN : TIPO_NUM;
          kp.key_strobe <= 1'b1;
          kp.key_down   <= 1'b1;
          count         <= '0;
          state         <= ST_RELEASE;
        end
        ST_RELEASE: begin
          // Column stays on the held key so other keys cannot start a new press
          if (tick) begin
            if (row_s == 4'hF) begin
              if (count == CW'(DEBOUNCE - 1)) begin
                count       <= '0;
                kp.key_down <= 1'b0;
                kp.col_n    <= {kp.col_n[2:0], kp.col_n[3]};
                state       <= ST_SCAN;
              end else begin
                count <= count + 1'b1;
              end
            end else begin
              count <= '0;
            end
          end
        end
        default: state <= ST_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with a resistive-matrix keypad model (SCAN_DIV=4, DEBOUNCE=3).
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] keys = 16'h0;
  logic [4:0]  exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          strobe_count = 0;
  logic        prev_strobe = 1'b0;

  keypad_scanner_if kif();

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kif)
  );

  always #5 clk = ~clk;

  // A held key at (r,c) pulls row r low whenever column c is driven low
  always_comb begin
    kif.row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      if (|(keys[r*4 +: 4] & ~kif.col_n)) kif.row_n[r] = 1'b0;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (kif.key_strobe) begin
      strobe_count++;
      checkOutput("strobe_width", int'(prev_strobe), 0);
      checkOutput("key_down_at_strobe", int'(kif.key_down), 1);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_strobe: got tipo=%0d number=%0h, expected no event at %0t",
                 kif.tipo, kif.number, $time);
      end else begin
        checkOutput("strobe_event", int'({kif.tipo, kif.number}), int'(exp_q.pop_front()));
      end
    end
    prev_strobe = kif.key_strobe;
  end

  task automatic applyStimulus(input int idx, input int hold);
    keys[idx] = 1'b1;
    repeat (hold) @(negedge clk);
    keys[idx] = 1'b0;
  endtask

  task automatic wait_release(input string name);
    int n = 0;
    while (kif.key_down && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, int'(kif.key_down), 0);
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_col(input logic [3:0] c, input string name);
    int n = 0;
    while (kif.col_n !== c && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, int'(kif.col_n), int'(c));
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, exp_q.size(), 0);
  endtask

  initial begin
    int n;
    int changes;
    int saved;
    logic [3:0] last_col;

    reset = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("reset_col_n", int'(kif.col_n), 4'b1110);
    checkOutput("reset_tipo", int'(kif.tipo), 0);
    checkOutput("reset_number", int'(kif.number), 0);
    checkOutput("reset_strobe", int'(kif.key_strobe), 0);
    checkOutput("reset_key_down", int'(kif.key_down), 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    $display("[TB] hold key 5 and release");
    exp_q.push_back({1'b0, 4'd5});
    keys[5] = 1'b1;
    repeat (200) @(negedge clk);
    checkOutput("t2_event_seen", exp_q.size(), 0);
    checkOutput("t2_key_down_held", int'(kif.key_down), 1);
    checkOutput("t2_number_hold", int'(kif.number), 5);
    keys[5] = 1'b0;
    n = 0;
    while (kif.key_down && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t2_release_latency", int'(n >= 10 && n <= 15), 1);
    checkOutput("t2_col_after_release", int'(kif.col_n), 4'b1011);
    n = 0;
    while (kif.col_n == 4'b1011 && n < 8) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t2_col_resume", int'(kif.col_n), 4'b0111);
    repeat (10) @(negedge clk);

    $display("[TB] bouncing key 1 then stable");
    exp_q.push_back({1'b0, 4'd1});
    for (int i = 0; i < 4; i++) begin
      keys[0] = ~keys[0];
      repeat (4) @(negedge clk);
    end
    applyStimulus(0, 100);
    drain("t4_bounce_event");
    wait_release("t4_bounce_release");

    $display("[TB] short glitch on key 1");
    saved = strobe_count;
    applyStimulus(0, 8);
    checkOutput("t4_glitch_key_down", int'(kif.key_down), 0);
    repeat (60) @(negedge clk);
    checkOutput("t4_glitch_no_event", strobe_count, saved);

    $display("[TB] ghost pattern on column 2");
    saved = strobe_count;
    keys[2] = 1'b1;
    keys[6] = 1'b1;
    repeat (30) @(negedge clk);
    changes = 0;
    last_col = kif.col_n;
    repeat (40) begin
      @(negedge clk);
      if (kif.col_n !== last_col) changes++;
      last_col = kif.col_n;
    end
    checkOutput("t5_ghost_rotates", int'(changes >= 8), 1);
    checkOutput("t5_ghost_key_down", int'(kif.key_down), 0);
    keys[2] = 1'b0;
    keys[6] = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("t5_ghost_no_event", strobe_count, saved);

    $display("[TB] sign keys");
    exp_q.push_back({1'b1, 4'b1100});
    applyStimulus(11, 100);
    drain("t3_equal_event");
    wait_release("t3_equal_release");
    exp_q.push_back({1'b1, 4'b1111});
    applyStimulus(12, 100);
    drain("t3_reset_key_event");
    checkOutput("t3_tipo_hold", int'(kif.tipo), 1);
    wait_release("t3_reset_key_release");

    $display("[TB] reset during debounce of key 9");
    wait_col(4'b0111, "t6_align_col3");
    keys[10] = 1'b1;
    wait_col(4'b1011, "t6_align_col2");
    saved = strobe_count;
    repeat (6) @(negedge clk);
    checkOutput("t6_no_early_event", strobe_count, saved);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("t6_reset_col_n", int'(kif.col_n), 4'b1110);
    checkOutput("t6_reset_tipo", int'(kif.tipo), 0);
    checkOutput("t6_reset_number", int'(kif.number), 0);
    checkOutput("t6_reset_key_down", int'(kif.key_down), 0);
    reset = 1'b0;
    exp_q.push_back({1'b0, 4'd9});
    repeat (100) @(negedge clk);
    drain("t6_fresh_event");
    keys[10] = 1'b0;
    wait_release("t6_release");

    checkOutput("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
